// File: rtl/frame_update_sequencer_pkg.sv
// Shared types and client index constants for the Galaga per-frame update sequencer.
package galaga_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} seq_state_t;

  localparam int CL_PLAYER  = 0;
  localparam int CL_PBULLET = 1;
  localparam int CL_ENEMY   = 2;
  localparam int CL_COLLIDE = 3;
endpackage

// File: rtl/frame_update_sequencer_if.sv
// Bundle between vga timing / update units and the frame update sequencer.
interface frame_update_sequencer_if #(
  parameter int N_CLIENTS = 4,
  parameter int FCNT_W    = 16
);
  logic                 vsync_n;
  logic                 pause;
  logic [N_CLIENTS-1:0] client_en;
  logic [N_CLIENTS-1:0] ack;
  logic [N_CLIENTS-1:0] req;
  logic                 tick;
  logic                 done;
  logic                 busy;
  logic [FCNT_W-1:0]    frame_cnt;
  logic [N_CLIENTS-1:0] fault;
  logic                 overrun;

  modport master (
    input  vsync_n, pause, client_en, ack,
    output req, tick, done, busy, frame_cnt, fault, overrun
  );

  modport slave (
    output vsync_n, pause, client_en, ack,
    input  req, tick, done, busy, frame_cnt, fault, overrun
  );
endinterface

// File: rtl/frame_update_sequencer_next_client_find.sv
// Combinational finder: lowest enabled client index at or above start.
module next_client_find #(
  parameter int N_CLIENTS = 4,
  parameter int IDX_W     = $clog2(N_CLIENTS + 1)
) (
  input  logic [N_CLIENTS-1:0] en,
  input  logic [IDX_W-1:0]     start,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);
  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (en[i] && (IDX_W'(i) >= start)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame sequencer: on vsync falling edge, serves enabled update units one at a time
// via req/ack, with per-client timeout, frame counting and overrun detection.
module frame_update_sequencer
  import galaga_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT   = 1024,
  parameter int FCNT_W    = 16
) (
  input logic                      clk,
  input logic                      reset,
  frame_update_sequencer_if.master bus
);
  localparam int IDX_W = $clog2(N_CLIENTS + 1);
  localparam int TMO_W = $clog2(TIMEOUT);

  seq_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 vs_prev_q;
  logic [N_CLIENTS-1:0] req_q, req_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [N_CLIENTS-1:0] fault_q, fault_d;
  logic                 overrun_q, overrun_d;

  logic                 vs_edge;
  logic                 fnd;
  logic [IDX_W-1:0]     fnd_idx;
  logic                 acked;

  next_client_find #(.N_CLIENTS(N_CLIENTS), .IDX_W(IDX_W)) u_find (
    .en    (bus.client_en),
    .start (idx_q),
    .found (fnd),
    .idx   (fnd_idx)
  );

  assign vs_edge = !bus.vsync_n && vs_prev_q;
  // req is one-hot on idx while in REQ, so masking ack with it picks ack[idx].
  assign acked   = |(bus.ack & req_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    fcnt_d    = fcnt_q;
    fault_d   = fault_q;
    overrun_d = overrun_q;

    if (vs_edge && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (vs_edge && !bus.pause) begin
          state_d = SCAN;
          idx_d   = '0;
          tick_d  = 1'b1;
        end
      end
      SCAN: begin
        if (fnd) begin
          state_d = REQ;
          idx_d   = fnd_idx;
          req_d   = N_CLIENTS'(1) << fnd_idx;
          tmo_d   = '0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      REQ: begin
        if (acked) begin
          req_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = SCAN;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          fault_d = fault_q | req_q;
          req_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = SCAN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        fcnt_d  = fcnt_q + FCNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      vs_prev_q <= 1'b1;
      req_q     <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      fcnt_q    <= '0;
      fault_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      vs_prev_q <= bus.vsync_n;
      req_q     <= req_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      fcnt_q    <= fcnt_d;
      fault_q   <= fault_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.req       = req_q;
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_cnt = fcnt_q;
  assign bus.fault     = fault_q;
  assign bus.overrun   = overrun_q;
endmodule
